// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART constants: byte width and FIFO depth used by the RX/TX paths
// and the baud generator.
package uart_rx_fifo_pkg;

  localparam int UART_NB_DATA = 8;
  localparam int UART_FIFO_AW = 4;

  function automatic int unsigned fifo_depth(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Byte/handshake bundle between UART receiver, RX FIFO and its consumer.
interface uart_rx_fifo_if #(
  parameter int NB_DATA = 8,
  parameter int ADDR_W  = 4
);

  logic [NB_DATA-1:0] i_rx_data;
  logic               i_rxdone;
  logic               i_rd;
  logic               i_clr_ovr;
  logic [NB_DATA-1:0] o_data;
  logic               o_empty;
  logic               o_full;
  logic [ADDR_W:0]    o_count;
  logic               o_overrun;

  modport slave (
    input  i_rx_data, i_rxdone, i_rd, i_clr_ovr,
    output o_data, o_empty, o_full, o_count, o_overrun
  );

  modport master (
    output i_rx_data, i_rxdone, i_rd, i_clr_ovr,
    input  o_data, o_empty, o_full, o_count, o_overrun
  );

endinterface

// File: rtl/uart_rx_fifo_ram.sv
// 2**ADDR_W x NB_DATA register array: one synchronous write port, one
// asynchronous read port. Shared by the RX and TX FIFOs.
module uart_fifo_ram #(
  parameter int NB_DATA = 8,
  parameter int ADDR_W  = 4
) (
  input  logic               clk,
  input  logic               i_we,
  input  logic [ADDR_W-1:0]  i_waddr,
  input  logic [NB_DATA-1:0] i_wdata,
  input  logic [ADDR_W-1:0]  i_raddr,
  output logic [NB_DATA-1:0] o_rdata
);

  logic [NB_DATA-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (i_we) mem_q[i_waddr] <= i_wdata;
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO behind the UART receiver; bytes that
// arrive while full are dropped and flagged by a sticky overrun bit.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int NB_DATA = UART_NB_DATA,
  parameter int ADDR_W  = UART_FIFO_AW
) (
  input  logic           clk,
  input  logic           i_reset,
  uart_rx_fifo_if.slave  bus
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q,  count_d;
  logic              rxdone_q;
  logic              ovr_q,    ovr_d;

  logic empty, full, push_ev, pop, wr_en, drop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign push_ev = bus.i_rxdone & ~rxdone_q;
  assign pop     = bus.i_rd & ~empty;
  // A simultaneous pop frees the slot the push needs, so full+pop accepts both.
  assign wr_en   = push_ev & (~full | pop);
  assign drop    = push_ev & full & ~pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovr_d    = ovr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    case ({wr_en, pop})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
    if (drop)               ovr_d = 1'b1;
    else if (bus.i_clr_ovr) ovr_d = 1'b0;
  end

  // rxdone_q resets high so a done level straddling reset release never pushes.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rxdone_q <= 1'b1;
      ovr_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rxdone_q <= bus.i_rxdone;
      ovr_q    <= ovr_d;
    end
  end

  uart_fifo_ram #(
    .NB_DATA (NB_DATA),
    .ADDR_W  (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (wr_en & ~i_reset),
    .i_waddr (wr_ptr_q),
    .i_wdata (bus.i_rx_data),
    .i_raddr (rd_ptr_q),
    .o_rdata (bus.o_data)
  );

  assign bus.o_empty   = empty;
  assign bus.o_full    = full;
  assign bus.o_count   = count_q;
  assign bus.o_overrun = ovr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed + random bench for uart_rx_fifo against a queue-based model of
// the receive buffer, checked on every falling edge.
module tb_uart_rx_fifo;

  localparam int NB = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic i_reset = 1'b0;
  always #5 clk = ~clk;

  uart_rx_fifo_if #(.NB_DATA(NB), .ADDR_W(AW)) bus();

  uart_rx_fifo #(.NB_DATA(NB), .ADDR_W(AW)) dut (
    .clk     (clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue plus sticky flag, updated from inputs seen at each edge.
  logic [NB-1:0] mq[$];
  bit m_ovr = 1'b0;
  bit m_prev_done = 1'b1;
  bit armed = 1'b0;

  always @(posedge clk) begin
    if (i_reset) begin
      mq.delete();
      m_ovr = 1'b0;
      m_prev_done = 1'b1;
      armed = 1'b1;
    end else begin
      bit push, do_pop, dropped;
      push = bus.i_rxdone && !m_prev_done;
      m_prev_done = bus.i_rxdone;
      do_pop = bus.i_rd && (mq.size() > 0);
      dropped = push && (mq.size() == DEPTH) && !do_pop;
      if (do_pop) void'(mq.pop_front());
      if (push && !dropped) mq.push_back(bus.i_rx_data);
      if (dropped) m_ovr = 1'b1;
      else if (bus.i_clr_ovr) m_ovr = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("cyc_count", 32'(bus.o_count), 32'(mq.size()));
      chk("cyc_empty", 32'(bus.o_empty), 32'(mq.size() == 0));
      chk("cyc_full", 32'(bus.o_full), 32'(mq.size() == DEPTH));
      chk("cyc_ovr", 32'(bus.o_overrun), 32'(m_ovr));
      if (mq.size() > 0) chk("cyc_data", 32'(bus.o_data), 32'(mq[0]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [NB-1:0] b);
    bus.i_rx_data = b;
    bus.i_rxdone = 1'b1;
    step();
    bus.i_rxdone = 1'b0;
    step();
  endtask

  task automatic pop1();
    bus.i_rd = 1'b1;
    step();
    bus.i_rd = 1'b0;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    step();
    step();
    i_reset = 1'b0;
    step();
  endtask

  initial begin
    bus.i_rx_data = '0;
    bus.i_rxdone  = 1'b0;
    bus.i_rd      = 1'b0;
    bus.i_clr_ovr = 1'b0;
    do_reset();
    chk("rst_count", 32'(bus.o_count), 0);
    chk("rst_empty", 32'(bus.o_empty), 1);
    chk("rst_full", 32'(bus.o_full), 0);
    chk("rst_ovr", 32'(bus.o_overrun), 0);

    // three bytes in, three out in order
    push(8'h11); push(8'h22); push(8'h33);
    chk("three_count", 32'(bus.o_count), 3);
    chk("three_head", 32'(bus.o_data), 32'h11);
    pop1(); chk("pop_22", 32'(bus.o_data), 32'h22);
    pop1(); chk("pop_33", 32'(bus.o_data), 32'h33);
    pop1(); chk("three_empty", 32'(bus.o_empty), 1);

    // long done level pushes once
    bus.i_rx_data = 8'hA5;
    bus.i_rxdone = 1'b1;
    repeat (5) step();
    bus.i_rxdone = 1'b0;
    step();
    chk("level_count", 32'(bus.o_count), 1);
    chk("level_data", 32'(bus.o_data), 32'hA5);
    pop1();

    // fill, overflow, drain
    for (int i = 0; i < DEPTH; i++) push(8'(i));
    chk("fill_full", 32'(bus.o_full), 1);
    push(8'hFF);
    chk("ovf_ovr", 32'(bus.o_overrun), 1);
    chk("ovf_count", 32'(bus.o_count), 16);
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_seq", 32'(bus.o_data), 32'(i));
      pop1();
    end
    chk("drain_empty", 32'(bus.o_empty), 1);
    bus.i_clr_ovr = 1'b1; step(); bus.i_clr_ovr = 1'b0;
    chk("clr_ovr", 32'(bus.o_overrun), 0);

    // push+pop at full
    for (int i = 0; i < DEPTH; i++) push(8'(i));
    bus.i_rx_data = 8'h40;
    bus.i_rxdone = 1'b1;
    bus.i_rd = 1'b1;
    step();
    bus.i_rxdone = 1'b0;
    bus.i_rd = 1'b0;
    chk("fullpp_count", 32'(bus.o_count), 16);
    chk("fullpp_ovr", 32'(bus.o_overrun), 0);
    chk("fullpp_head", 32'(bus.o_data), 32'h01);
    step();
    for (int i = 1; i < DEPTH; i++) begin
      chk("fullpp_drain", 32'(bus.o_data), 32'(i));
      pop1();
    end
    chk("fullpp_last", 32'(bus.o_data), 32'h40);
    pop1();

    // push+pop on empty
    bus.i_rx_data = 8'h5A;
    bus.i_rxdone = 1'b1;
    bus.i_rd = 1'b1;
    step();
    bus.i_rxdone = 1'b0;
    bus.i_rd = 1'b0;
    chk("emptypp_count", 32'(bus.o_count), 1);
    chk("emptypp_data", 32'(bus.o_data), 32'h5A);
    pop1();
    pop1();
    chk("pop_empty_count", 32'(bus.o_count), 0);

    // set beats clear
    for (int i = 0; i < DEPTH; i++) push(8'(i + 32));
    push(8'hEE);
    chk("ovr2_set", 32'(bus.o_overrun), 1);
    bus.i_rx_data = 8'h77;
    bus.i_rxdone = 1'b1;
    bus.i_clr_ovr = 1'b1;
    step();
    bus.i_rxdone = 1'b0;
    bus.i_clr_ovr = 1'b0;
    chk("ovr_set_prio", 32'(bus.o_overrun), 1);
    step();
    bus.i_clr_ovr = 1'b1; step(); bus.i_clr_ovr = 1'b0;
    chk("ovr_clr_alone", 32'(bus.o_overrun), 0);

    // reset mid-operation with done held across release
    do_reset();
    for (int i = 0; i < 7; i++) push(8'(i + 100));
    chk("pre_rst_count", 32'(bus.o_count), 7);
    bus.i_rx_data = 8'h99;
    bus.i_rxdone = 1'b1;
    i_reset = 1'b1;
    step(); step();
    i_reset = 1'b0;
    step(); step(); step();
    chk("rst_mid_count", 32'(bus.o_count), 0);
    chk("rst_mid_empty", 32'(bus.o_empty), 1);
    bus.i_rxdone = 1'b0;
    step();
    chk("rst_mid_nopush", 32'(bus.o_count), 0);
    push(8'h3C);
    chk("rst_mid_repush", 32'(bus.o_count), 1);
    chk("rst_mid_data", 32'(bus.o_data), 32'h3C);

    // random traffic with varying consumer rates
    for (int blk = 0; blk < 15; blk++) begin
      int rd_pct;
      rd_pct = (blk % 3 == 0) ? 10 : ((blk % 3 == 1) ? 50 : 90);
      for (int c = 0; c < 200; c++) begin
        bus.i_rx_data = 8'($urandom);
        bus.i_rxdone  = ($urandom_range(0, 99) < 40);
        bus.i_rd      = ($urandom_range(0, 99) < rd_pct);
        bus.i_clr_ovr = ($urandom_range(0, 99) < 3);
        i_reset       = ($urandom_range(0, 999) < 3);
        step();
      end
    end
    i_reset = 1'b0;
    bus.i_rxdone = 1'b0;
    bus.i_rd = 1'b0;
    bus.i_clr_ovr = 1'b0;
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive buffer directly downstream of the UART receiver.
- Captures each completed byte (data bus + one-cycle done pulse) into a first-word-fall-through FIFO.
- The host side pops bytes at its own pace; bytes arriving while full are counted as overrun, never silently lost.
- Decouples serial byte arrival from the consumer logic (command decoder / register bridge).

Parameters:
NB_DATA, 8, width of received byte
ADDR_W, 4, log2 of FIFO depth (depth = 2**ADDR_W = 16)

Ports:
clk  input  1  system clock
i_reset  input  1  reset; synchronous, active-high
i_rx_data  input  NB_DATA  byte from UART receiver, valid while i_rxdone high
i_rxdone  input  1  receiver done pulse (nominally one cycle; longer levels tolerated)
i_rd  input  1  pop request from consumer
i_clr_ovr  input  1  clears sticky overrun flag
o_data  output  NB_DATA  head-of-FIFO byte, valid when o_empty low
o_empty  output  1  FIFO holds no bytes
o_full  output  1  FIFO holds 2**ADDR_W bytes
o_count  output  ADDR_W+1  current occupancy, 0..2**ADDR_W
o_overrun  output  1  sticky: a byte was dropped because FIFO was full

Behaviour:
- Reset (i_reset=1 at posedge): wr/rd pointers=0, count=0, o_empty=1, o_full=0, o_overrun=0. Memory contents are not cleared; o_data is don't-care while empty. rxdone_q is set to 1 so a done level held through reset release does not push.
- Push event: i_rxdone=1 and rxdone_q=0 (rising edge). rxdone_q <= i_rxdone every cycle. A multi-cycle done level pushes exactly once.
- Push writes i_rx_data sampled in the edge cycle. Latency: on a push into an empty FIFO, o_empty falls and o_data is valid on the next cycle.
- Pop: i_rd=1 and o_empty=0. Read pointer advances at the clock edge. o_data is combinational from mem[rd_ptr] (FWFT), so the next byte shows the following cycle. i_rd while empty is ignored with no state change.
- Full and push without pop: byte is dropped; o_overrun <= 1; pointers and count unchanged.
- Full and push with valid pop in the same cycle: both are accepted; count stays at 2**ADDR_W; no overrun.
- Empty and push with i_rd in the same cycle: pop is ignored (empty), push is accepted; count becomes 1.
- Push and pop with 0<count<full: both execute; count unchanged.
- Pointers are ADDR_W bits and wrap modulo depth. o_count is a separate counter (+1 push only, -1 pop only).
- Flags are combinational from the count: o_empty = (count==0), o_full = (count==2**ADDR_W).
- Overrun flag: set has priority over i_clr_ovr in the same cycle. Otherwise i_clr_ovr clears it.
- Reset mid-operation (including during a done pulse): all state returns to reset values and the in-flight byte is discarded.

Decomposition:
- Shared uart package: NB_DATA default and a FIFO depth constant, shared with uart_rx, the baud generator and the future TX FIFO.
- One natural sub-module: uart_fifo_ram. It is a 2**ADDR_W x NB_DATA register array with one synchronous write port and one asynchronous read port. The same sub-module is reused for the TX FIFO.
- Pointer, count, edge-detect and overrun logic stay in uart_rx_fifo.

Test Plan:
- Reset, then three done pulses with bytes 0x11, 0x22, 0x33 -> o_count=3; o_data=0x11. Three single-cycle pops return 0x11, 0x22, 0x33 in order; o_empty=1 after the third.
- A done level held high for 5 cycles with 0xA5 -> exactly one push; o_count=1.
- Push 16 bytes 0x00..0x0F -> o_full=1. A 17th push (0xFF) -> o_overrun=1, o_count=16. Draining reads 0x00..0x0F with no 0xFF.
- At full, push 0x40 with i_rd in the same cycle -> o_count stays 16, o_overrun stays 0, o_data advances to 0x01. The last byte drained is 0x40.
- Empty FIFO, push 0x5A with i_rd high in the same cycle -> next cycle o_count=1, o_data=0x5A. Pop on an empty FIFO leaves o_count=0.
- Overrun set, then i_clr_ovr coinciding with a new overflow push -> o_overrun stays 1. i_clr_ovr alone -> 0.
- i_reset asserted with o_count=7 while i_rxdone is high, then released with done still high -> o_count=0, o_empty=1, no push until done falls and rises again.
